// File: rtl/note_stabilizer.sv
// note_stabilizer
//   Temporal filter for the per-frame note interpreter. A note is published
//   only after CONFIRM_FRAMES consecutive identical frames, and a published
//   note survives up to HOLD_FRAMES-1 consecutive non-matching frames. While
//   a note is locked, a different note that is itself confirmed replaces it
//   directly, with no intervening "no note" output.
//
// Ports
//   clk          system clock
//   rst          asynchronous, active-high reset
//   frame_valid  one-cycle strobe; note_in is sampled only when high
//   note_in      one-hot {C,D,E,G,A} (MSB = C), or 0 for no note
//   note_out     stable one-hot note, 0 when none
//   note_idx     encoded note_out: 0 none, 1 C, 2 D, 3 E, 4 G, 5 A
//   note_valid   high while note_out is nonzero
//   note_change  one-cycle pulse on every change of note_out
//   illegal_seen sticky; set by any sampled note_in with more than one bit set
module note_stabilizer #(
  parameter int unsigned CONFIRM_FRAMES = 3,
  parameter int unsigned HOLD_FRAMES    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_valid,
  input  logic [4:0] note_in,
  output logic [4:0] note_out,
  output logic [2:0] note_idx,
  output logic       note_valid,
  output logic       note_change,
  output logic       illegal_seen
);

  localparam logic [3:0] CONF = 4'(CONFIRM_FRAMES);
  localparam logic [3:0] HOLD = 4'(HOLD_FRAMES);

  typedef enum logic [1:0] {IDLE, CAND, LOCKED} state_t;

  state_t     state, state_n;
  logic [4:0] cand, cand_n;
  logic [3:0] cnt, cnt_n;
  logic [4:0] chal, chal_n;
  logic [3:0] chal_cnt, chal_cnt_n;
  logic [3:0] miss, miss_n;
  logic [4:0] out_n;
  logic       ill_n;
  logic       multi, zero;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic logic [2:0] enc(input logic [4:0] n);
    case (n)
      5'b10000: return 3'd1;
      5'b01000: return 3'd2;
      5'b00100: return 3'd3;
      5'b00010: return 3'd4;
      5'b00001: return 3'd5;
      default:  return 3'd0;
    endcase
  endfunction

  // More than one bit set: clearing the lowest set bit leaves something.
  assign multi = |(note_in & (note_in - 5'd1));
  assign zero  = (note_in == 5'd0) || multi;

  always_comb begin
    state_n    = state;
    cand_n     = cand;
    cnt_n      = cnt;
    chal_n     = chal;
    chal_cnt_n = chal_cnt;
    miss_n     = miss;
    out_n      = note_out;
    ill_n      = illegal_seen;

    if (frame_valid) begin
      if (multi) ill_n = 1'b1;

      case (state)
        IDLE: begin
          if (!zero) begin
            cand_n  = note_in;
            cnt_n   = 4'd1;
            state_n = CAND;
            // CONFIRM_FRAMES == 1 locks on the very first frame.
            if (cnt_n >= CONF) begin
              state_n    = LOCKED;
              out_n      = note_in;
              cnt_n      = 4'd0;
              miss_n     = 4'd0;
              chal_cnt_n = 4'd0;
            end
          end
        end

        CAND: begin
          if (zero) begin
            state_n = IDLE;
            cnt_n   = 4'd0;
          end else if (note_in == cand) begin
            cnt_n = sat_inc(cnt);
            if (cnt_n >= CONF) begin
              state_n    = LOCKED;
              out_n      = cand;
              cnt_n      = 4'd0;
              miss_n     = 4'd0;
              chal_cnt_n = 4'd0;
            end
          end else begin
            cand_n = note_in;
            cnt_n  = 4'd1;
          end
        end

        LOCKED: begin
          if (zero) begin
            miss_n     = sat_inc(miss);
            chal_cnt_n = 4'd0;
          end else if (note_in == note_out) begin
            miss_n     = 4'd0;
            chal_cnt_n = 4'd0;
          end else if (note_in == chal) begin
            chal_cnt_n = sat_inc(chal_cnt);
            miss_n     = sat_inc(miss);
          end else begin
            chal_n     = note_in;
            chal_cnt_n = 4'd1;
            miss_n     = sat_inc(miss);
          end

          // A confirmed challenger takes precedence over the hold timeout.
          if (chal_cnt_n >= CONF) begin
            out_n      = chal_n;
            miss_n     = 4'd0;
            chal_cnt_n = 4'd0;
          end else if (miss_n >= HOLD) begin
            state_n    = IDLE;
            out_n      = 5'd0;
            cnt_n      = 4'd0;
            miss_n     = 4'd0;
            chal_cnt_n = 4'd0;
          end
        end

        default: begin
          state_n    = IDLE;
          out_n      = 5'd0;
          cnt_n      = 4'd0;
          miss_n     = 4'd0;
          chal_cnt_n = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cand         <= 5'd0;
      cnt          <= 4'd0;
      chal         <= 5'd0;
      chal_cnt     <= 4'd0;
      miss         <= 4'd0;
      note_out     <= 5'd0;
      note_idx     <= 3'd0;
      note_valid   <= 1'b0;
      note_change  <= 1'b0;
      illegal_seen <= 1'b0;
    end else begin
      state        <= state_n;
      cand         <= cand_n;
      cnt          <= cnt_n;
      chal         <= chal_n;
      chal_cnt     <= chal_cnt_n;
      miss         <= miss_n;
      note_out     <= out_n;
      note_idx     <= enc(out_n);
      note_valid   <= |out_n;
      note_change  <= (out_n != note_out);
      illegal_seen <= ill_n;
    end
  end

endmodule

// File: tb/tb_note_stabilizer.sv
module tb_note_stabilizer;

  localparam int C_FR = 3;
  localparam int H_FR = 8;

  localparam logic [4:0] NC = 5'b10000;
  localparam logic [4:0] ND = 5'b01000;
  localparam logic [4:0] NE = 5'b00100;
  localparam logic [4:0] NG = 5'b00010;
  localparam logic [4:0] NA = 5'b00001;
  localparam logic [4:0] NZ = 5'b00000;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_valid;
  logic [4:0] note_in;
  logic [4:0] note_out;
  logic [2:0] note_idx;
  logic       note_valid;
  logic       note_change;
  logic       illegal_seen;

  note_stabilizer #(.CONFIRM_FRAMES(C_FR), .HOLD_FRAMES(H_FR)) dut (
    .clk(clk), .rst(rst), .frame_valid(frame_valid), .note_in(note_in),
    .note_out(note_out), .note_idx(note_idx), .note_valid(note_valid),
    .note_change(note_change), .illegal_seen(illegal_seen)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: one trailing run of identical legal frames since the
  // last output event, plus a count of frames since the locked note was
  // last seen.
  logic [4:0] m_out;
  logic [4:0] run_note;
  int         run_len;
  int         m_miss;
  bit         m_ill;
  bit         m_chg;

  function automatic int idx_of(input logic [4:0] n);
    logic [4:0] tbl [0:4];
    tbl = '{NC, ND, NE, NG, NA};
    for (int i = 0; i < 5; i++) if (n == tbl[i]) return i + 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_out = '0; run_note = '0; run_len = 0; m_miss = 0; m_ill = 0; m_chg = 0;
  endtask

  task automatic model_step(input bit fv, input logic [4:0] n);
    logic [4:0] prev;
    bit         z;
    prev  = m_out;
    m_chg = 0;
    if (fv) begin
      if ($countones(n) > 1) m_ill = 1;
      z = ($countones(n) != 1);
      if (z) run_len = 0;
      else if (n == run_note) run_len = (run_len < 15) ? run_len + 1 : 15;
      else begin run_note = n; run_len = 1; end

      if (m_out == 0) begin
        if (run_len >= C_FR) begin m_out = run_note; run_len = 0; m_miss = 0; end
      end else begin
        if (!z && n == m_out) m_miss = 0;
        else m_miss = (m_miss < 15) ? m_miss + 1 : 15;
        if (run_len >= C_FR && run_note != m_out) begin
          m_out = run_note; run_len = 0; m_miss = 0;
        end else if (m_miss >= H_FR) begin
          m_out = '0; run_len = 0; m_miss = 0;
        end
      end
      m_chg = (m_out != prev);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".out"},    int'(note_out),     int'(m_out));
    chk({tag, ".idx"},    int'(note_idx),     idx_of(m_out));
    chk({tag, ".valid"},  int'(note_valid),   int'(m_out != 0));
    chk({tag, ".change"}, int'(note_change),  int'(m_chg));
    chk({tag, ".ill"},    int'(illegal_seen), int'(m_ill));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".out"},    int'(note_out),     0);
    chk({tag, ".idx"},    int'(note_idx),     0);
    chk({tag, ".valid"},  int'(note_valid),   0);
    chk({tag, ".change"}, int'(note_change),  0);
    chk({tag, ".ill"},    int'(illegal_seen), 0);
  endtask

  task automatic step(input bit fv, input logic [4:0] n);
    @(negedge clk);
    frame_valid = fv;
    note_in     = n;
    @(posedge clk);
    model_step(fv, n);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; frame_valid = 1'b0; note_in = '0;
    #2 chk_zero("rst_active");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1 chk_zero("rst_release");
  endtask

  typedef struct {
    bit         r;
    bit         fv;
    logic [4:0] n;
    logic [4:0] eo;
    bit         ec;
    bit         ei;
  } vec_t;

  vec_t vt[$];

  task automatic add(input bit r, input bit fv, input logic [4:0] n,
                     input logic [4:0] eo, input bit ec, input bit ei);
    vec_t v;
    v.r = r; v.fv = fv; v.n = n; v.eo = eo; v.ec = ec; v.ei = ei;
    vt.push_back(v);
  endtask

  initial begin
    logic [4:0] cur;
    logic [4:0] n;
    bit         fv;
    int         r;

    rst = 1'b1; frame_valid = 1'b0; note_in = '0;
    model_reset();

    // Adoption of E
    add(1, 1, NE, NZ, 0, 0);
    add(0, 1, NE, NZ, 0, 0);
    add(0, 1, NE, NE, 1, 0);
    add(0, 0, NZ, NE, 0, 0);
    // Glitch rejection: D D 0 D D D
    add(1, 1, ND, NZ, 0, 0);
    add(0, 1, ND, NZ, 0, 0);
    add(0, 1, NZ, NZ, 0, 0);
    add(0, 1, ND, NZ, 0, 0);
    add(0, 1, ND, NZ, 0, 0);
    add(0, 1, ND, ND, 1, 0);
    // Hold and release on A: 7 zeros hold, 8th releases
    add(1, 1, NA, NZ, 0, 0);
    add(0, 1, NA, NZ, 0, 0);
    add(0, 1, NA, NA, 1, 0);
    for (int i = 0; i < 7; i++) add(0, 1, NZ, NA, 0, 0);
    add(0, 1, NZ, NZ, 1, 0);
    add(0, 0, NZ, NZ, 0, 0);
    // Direct switch C -> G
    add(1, 1, NC, NZ, 0, 0);
    add(0, 1, NC, NZ, 0, 0);
    add(0, 1, NC, NC, 1, 0);
    add(0, 1, NG, NC, 0, 0);
    add(0, 1, NG, NC, 0, 0);
    add(0, 1, NG, NG, 1, 0);
    // Interrupted challenger: C locked, G 0 G G stays C, 5th G switches
    add(1, 1, NC, NZ, 0, 0);
    add(0, 1, NC, NZ, 0, 0);
    add(0, 1, NC, NC, 1, 0);
    add(0, 1, NG, NC, 0, 0);
    add(0, 1, NZ, NC, 0, 0);
    add(0, 1, NG, NC, 0, 0);
    add(0, 1, NG, NC, 0, 0);
    add(0, 1, NG, NG, 1, 0);
    // Illegal input: ignored without strobe, flagged with strobe
    add(1, 0, 5'b11111, NZ, 0, 0);
    add(0, 1, 5'b11000, NZ, 0, 1);
    add(0, 1, NE, NZ, 0, 1);
    add(0, 1, NE, NZ, 0, 1);
    add(0, 1, NE, NE, 1, 1);

    foreach (vt[i]) begin
      if (vt[i].r) do_reset();
      step(vt[i].fv, vt[i].n);
      chk($sformatf("vec%0d.out", i),    int'(note_out),     int'(vt[i].eo));
      chk($sformatf("vec%0d.idx", i),    int'(note_idx),     idx_of(vt[i].eo));
      chk($sformatf("vec%0d.valid", i),  int'(note_valid),   int'(vt[i].eo != 0));
      chk($sformatf("vec%0d.change", i), int'(note_change),  int'(vt[i].ec));
      chk($sformatf("vec%0d.ill", i),    int'(illegal_seen), int'(vt[i].ei));
      chk_model($sformatf("vec%0d.model", i));
    end

    // Async reset while a note is locked: outputs clear before the next edge.
    do_reset();
    step(1, NE); step(1, NE); step(1, NE);
    chk("lock_before_rst", int'(note_out), int'(NE));
    @(negedge clk); frame_valid = 1'b0;
    @(posedge clk); #3 rst = 1'b1;
    #1 chk_zero("async_rst_locked");
    model_reset();
    @(negedge clk); rst = 1'b0;

    // Async reset after 2 of 3 confirming strobes: count restarts.
    step(1, NE); step(1, NE);
    @(negedge clk); frame_valid = 1'b0;
    @(posedge clk); #3 rst = 1'b1;
    #1 chk_zero("async_rst_cand");
    model_reset();
    @(negedge clk); rst = 1'b0;
    step(1, NE); chk("post_rst_f1", int'(note_out), 0);
    step(1, NE); chk("post_rst_f2", int'(note_out), 0);
    step(1, NE); chk("post_rst_f3", int'(note_out), int'(NE));
    chk("post_rst_f3_chg", int'(note_change), 1);

    // Randomized run against the model
    do_reset();
    cur = NE;
    for (int i = 0; i < 800; i++) begin
      if (i % 200 == 199) do_reset();
      r = $urandom % 100;
      if (r < 12) cur = 5'b00001 << ($urandom % 5);
      n = cur;
      if (r >= 12 && r < 22) n = '0;
      else if (r >= 22 && r < 24) begin
        n = 5'($urandom % 32);
        if ($countones(n) < 2) n = 5'b10001;
      end
      fv = ($urandom % 5) != 0;
      step(fv, n);
      chk_model($sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/note_stabilizer.md
# note_stabilizer

Temporal filter that sits directly downstream of the per-frame note interpreter. It consumes the interpreter's 5-bit one-hot note decision (C, D, E, G, A, MSB = C) once per analysis frame. It publishes a debounced note only after it has been confirmed over several consecutive frames, and holds it through short dropouts. Its outputs drive the LED/seven-segment display and note-event logic.

## Interface
Parameters:
- CONFIRM_FRAMES, 3, consecutive identical frames needed to adopt a note (legal range 1..15)
- HOLD_FRAMES, 8, consecutive non-matching frames tolerated before releasing a locked note (legal range 1..15)

Ports:
- clk  in  1  system clock; the only clock
- rst  in  1  asynchronous, active-high reset
- frame_valid  in  1  one-cycle strobe; note_in is sampled only when high
- note_in  in  5  interpreter decision: one-hot {C,D,E,G,A}, or 0 for no note
- note_out  out  5  stable one-hot note, 0 when none
- note_idx  out  3  encoded note_out: 0 none, 1 C, 2 D, 3 E, 4 G, 5 A
- note_valid  out  1  high while note_out is nonzero
- note_change  out  1  one-cycle pulse on every change of note_out
- illegal_seen  out  1  sticky flag; set by any sampled note_in with more than one bit high

## Operation
- Input classification happens only on frame_valid:
  - zero: note_in == 0, or illegal (more than one bit high); illegal also sets illegal_seen.
  - same: equal to the tracked candidate or locked note.
  - other: a different legal one-hot value.
- State IDLE (note_out = 0):
  - Legal note: cand <= note_in, cnt <= 1. If CONFIRM_FRAMES == 1, go to LOCKED and publish immediately; otherwise go to CAND.
  - Zero: stay in IDLE.
- State CAND:
  - same: cnt++. When cnt reaches CONFIRM_FRAMES, go to LOCKED, note_out <= cand, pulse note_change.
  - other: cand <= note_in, cnt <= 1.
  - zero: go to IDLE, cnt <= 0.
- State LOCKED (note_out = locked note):
  - same: miss <= 0, challenger count <= 0.
  - other, matching the current challenger: chal_cnt++, miss++.
  - other, new challenger: chal <= note_in, chal_cnt <= 1, miss++.
  - zero: miss++, chal_cnt <= 0.
  - If chal_cnt reaches CONFIRM_FRAMES: note_out <= chal, miss <= 0, chal_cnt <= 0, pulse note_change, stay in LOCKED.
  - Else if miss reaches HOLD_FRAMES: go to IDLE, note_out <= 0, pulse note_change.
  - If both conditions occur on the same frame, the challenger switch wins.
- Counters are 4 bits and saturating; they never wrap.
- note_idx and note_valid are registered together with note_out and are always mutually consistent.
- frame_valid low: all state holds; note_in is don't-care.

## Timing
- All outputs are registered. A frame strobed in cycle N is reflected on the outputs in cycle N+1.
- Best-case adoption latency from IDLE: the CONFIRM_FRAMES-th matching strobe, plus 1 cycle.
- Release latency: the HOLD_FRAMES-th non-matching strobe, plus 1 cycle.
- note_change is high for exactly one cycle per output change and never on a cycle with no change.
- Back-to-back strobes (frame_valid high on consecutive cycles) are legal; each one is a separate frame.
- Reset, asynchronous at any time including mid-confirmation:
  - state IDLE; note_out = 0, note_idx = 0, note_valid = 0, note_change = 0, illegal_seen = 0; all counters 0.
  - The first strobe after rst deasserts is treated as frame 1.

## Test plan
- Adoption: rst, then 3 strobes of note_in = 5'b00100 → note_out = 00100, note_idx = 3, note_valid = 1, a single note_change pulse 1 cycle after the 3rd strobe; no output change after strobes 1–2.
- Glitch rejection: D, D, 0, D, D, D → adoption only after the final D (the counter restarts at the zero frame).
- Hold and release: lock on A, then 7 zero strobes → still A; 8th zero → note_out = 0, note_idx = 0, one note_change pulse.
- Direct switch: lock on C, then G, G, G → note_out = 00010 after the 3rd G, with no intermediate 0 output; lock on C, then G, 0, G, G → stays C.
- Illegal input: strobe note_in = 5'b11000 while IDLE → illegal_seen = 1 and note_out unchanged; with frame_valid low and note_in = 5'b11111 → no effect.
- Reset mid-operation: assert rst asynchronously (between clock edges) after 2 of 3 confirming strobes → outputs 0 immediately; after release, 2 further strobes do not lock, and the 3rd does.
